// File: rtl/cache_fsm_l3_responder.sv
// Shared direct-mapped, write-back L3 controller answering L2 read-line and write-back requests,
// backed by main memory over a req/ready handshake.
module cache_fsm_l3_responder #(
    parameter int unsigned ADDRESS_WIDTH          = 32,
    parameter int unsigned MAIN_MEMORY_DATA_WIDTH = 128,
    parameter int unsigned L3_INDEX_WIDTH         = 6,
    parameter int unsigned LINE_OFFSET_BITS       = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              read_from_L3_request,
    input  logic                              write_back_to_L3_request,
    input  logic [ADDRESS_WIDTH-1:0]          cache_L3_memory_address,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] write_back_to_L3_data,
    output logic                              L3_ready,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0] write_data_to_L2_from_L3,
    output logic                              write_back_to_L3_verified,
    output logic                              main_memory_read_request,
    output logic                              main_memory_write_request,
    output logic [ADDRESS_WIDTH-1:0]          main_memory_address,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0] main_memory_write_data,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] main_memory_read_data,
    input  logic                              main_memory_ready,
    output logic                              L3_cache_hit,
    output logic                              L3_cache_miss
);
    localparam int unsigned AW     = ADDRESS_WIDTH;
    localparam int unsigned MDW    = MAIN_MEMORY_DATA_WIDTH;
    localparam int unsigned IW     = L3_INDEX_WIDTH;
    localparam int unsigned LINE_W = AW - 2 - LINE_OFFSET_BITS;
    localparam int unsigned TAG_W  = LINE_W - IW;
    localparam int unsigned LINES  = 1 << IW;

    typedef enum logic [2:0] {IDLE, COMPARE, EVICT, FETCH, RESPOND} state_t;

    state_t             state, state_next;
    logic [LINE_W-1:0]  req_line;
    logic               req_wb;
    logic [MDW-1:0]     req_data;

    logic [LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [MDW-1:0]     data_mem [LINES];

    logic [IW-1:0]      idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit_c, victim_dirty_c;

    logic               arr_we, flag_we, flag_valid, flag_dirty;
    logic [MDW-1:0]     arr_data;
    logic               l3_ready_d, verified_d, rd_req_d, wr_req_d, hit_d, miss_d;
    logic [MDW-1:0]     l2_data_d, mm_wdata_d;
    logic [AW-1:0]      mm_addr_d;

    // Processor-ID and byte-offset bits are deliberately dropped: the L3 is shared and line-granular.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cache_L3_memory_address[AW-1:AW-2],
                                cache_L3_memory_address[LINE_OFFSET_BITS-1:0]};

    assign idx            = req_line[IW-1:0];
    assign req_tag        = req_line[LINE_W-1:IW];
    assign hit_c          = valid_q[idx] && (tag_mem[idx] == req_tag);
    assign victim_dirty_c = valid_q[idx] && dirty_q[idx];

    // Next state, array updates and next values of every registered output.
    always_comb begin
        state_next = state;
        arr_we     = 1'b0;
        arr_data   = req_data;
        flag_we    = 1'b0;
        flag_valid = 1'b0;
        flag_dirty = 1'b0;
        l3_ready_d = 1'b0;
        verified_d = 1'b0;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        l2_data_d  = '0;
        mm_wdata_d = '0;
        mm_addr_d  = '0;
        case (state)
            IDLE: begin
                if (write_back_to_L3_request || read_from_L3_request) state_next = COMPARE;
            end
            COMPARE: begin
                hit_d  = hit_c;
                miss_d = !hit_c;
                if (hit_c) begin
                    state_next = RESPOND;
                    if (req_wb) begin
                        arr_we     = 1'b1;
                        flag_we    = 1'b1;
                        flag_valid = 1'b1;
                        flag_dirty = 1'b1;
                    end
                end else if (victim_dirty_c) begin
                    state_next = EVICT;
                end else if (req_wb) begin
                    state_next = RESPOND;
                    arr_we     = 1'b1;
                    flag_we    = 1'b1;
                    flag_valid = 1'b1;
                    flag_dirty = 1'b1;
                end else begin
                    state_next = FETCH;
                end
            end
            EVICT: begin
                if (main_memory_ready) begin
                    flag_we    = 1'b1;
                    flag_valid = 1'b1;
                    if (req_wb) begin
                        state_next = RESPOND;
                        arr_we     = 1'b1;
                        flag_dirty = 1'b1;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (main_memory_ready) begin
                    state_next = RESPOND;
                    arr_we     = 1'b1;
                    arr_data   = main_memory_read_data;
                    flag_we    = 1'b1;
                    flag_valid = 1'b1;
                end
            end
            RESPOND: begin
                state_next = IDLE;
                if (req_wb) begin
                    verified_d = 1'b1;
                end else begin
                    l3_ready_d = 1'b1;
                    l2_data_d  = data_mem[idx];
                end
            end
            default: state_next = IDLE;
        endcase
        // Memory request lines follow the state being entered so they are stable until ready.
        if (state_next == EVICT) begin
            wr_req_d   = 1'b1;
            mm_addr_d  = AW'({tag_mem[idx], idx}) << LINE_OFFSET_BITS;
            mm_wdata_d = data_mem[idx];
        end else if (state_next == FETCH) begin
            rd_req_d   = 1'b1;
            mm_addr_d  = AW'(req_line) << LINE_OFFSET_BITS;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            req_line <= '0;
            req_wb   <= 1'b0;
            req_data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (write_back_to_L3_request || read_from_L3_request)) begin
                req_wb   <= write_back_to_L3_request;
                req_line <= cache_L3_memory_address[AW-3:LINE_OFFSET_BITS];
                req_data <= write_back_to_L3_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (flag_we) begin
            valid_q[idx] <= flag_valid;
            dirty_q[idx] <= flag_dirty;
        end
    end

    // Tag and data storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[idx]  <= req_tag;
            data_mem[idx] <= arr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            L3_ready                  <= 1'b0;
            write_data_to_L2_from_L3  <= '0;
            write_back_to_L3_verified <= 1'b0;
            main_memory_read_request  <= 1'b0;
            main_memory_write_request <= 1'b0;
            main_memory_address       <= '0;
            main_memory_write_data    <= '0;
            L3_cache_hit              <= 1'b0;
            L3_cache_miss             <= 1'b0;
        end else begin
            L3_ready                  <= l3_ready_d;
            write_data_to_L2_from_L3  <= l2_data_d;
            write_back_to_L3_verified <= verified_d;
            main_memory_read_request  <= rd_req_d;
            main_memory_write_request <= wr_req_d;
            main_memory_address       <= mm_addr_d;
            main_memory_write_data    <= mm_wdata_d;
            L3_cache_hit              <= hit_d;
            L3_cache_miss             <= miss_d;
        end
    end
endmodule

// File: tb/tb_cache_fsm_l3_responder.sv
// Directed bench for the L3 responder: a one-cycle-latency memory model plus scenario tasks
// with hand-computed latencies, addresses and line data.
module tb_cache_fsm_l3_responder;
    localparam logic [127:0] D1 = {4{32'h1111_1111}};
    localparam logic [127:0] D2 = {4{32'h2222_2222}};
    localparam logic [127:0] D3 = {4{32'h3333_3333}};
    localparam logic [127:0] D4 = {4{32'h4444_4444}};
    localparam logic [127:0] D6 = {4{32'h6666_6666}};
    localparam logic [127:0] D7 = {4{32'h7777_7777}};
    localparam logic [127:0] D8 = {4{32'h8888_8888}};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         rd_req = 1'b0, wb_req = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] wb_data = '0;
    logic         l3_ready, verified, mm_rreq, mm_wreq, mm_ready, hit, miss;
    logic [127:0] l2_data, mm_wdata, mm_rdata;
    logic [31:0]  mm_addr;

    int tests = 0, fails = 0;
    int mem_reads = 0, mem_writes = 0, hits = 0, misses = 0;
    logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;

    cache_fsm_l3_responder dut (
        .clk(clk), .reset(reset),
        .read_from_L3_request(rd_req), .write_back_to_L3_request(wb_req),
        .cache_L3_memory_address(req_addr), .write_back_to_L3_data(wb_data),
        .L3_ready(l3_ready), .write_data_to_L2_from_L3(l2_data),
        .write_back_to_L3_verified(verified),
        .main_memory_read_request(mm_rreq), .main_memory_write_request(mm_wreq),
        .main_memory_address(mm_addr), .main_memory_write_data(mm_wdata),
        .main_memory_read_data(mm_rdata), .main_memory_ready(mm_ready),
        .L3_cache_hit(hit), .L3_cache_miss(miss)
    );

    always #5 clk = ~clk;

    // Memory answers a request with a one-cycle ready pulse on the edge after it first sees it.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mm_ready <= 1'b0;
        end else begin
            mm_ready <= 1'b0;
            if (!mm_ready && (mm_rreq || mm_wreq)) begin
                mm_ready <= 1'b1;
                if (mm_wreq) begin
                    mem_writes   <= mem_writes + 1;
                    last_wr_addr <= mm_addr;
                    last_wr_data <= mm_wdata;
                end else begin
                    mem_reads    <= mem_reads + 1;
                    last_rd_addr <= mm_addr;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (hit)  hits   <= hits + 1;
        if (miss) misses <= misses + 1;
    end

    // Issue one request at a negedge; lat = edges after the sampling edge until the pulse is seen.
    task automatic do_req(input bit is_wb, input logic [31:0] a, input logic [127:0] d,
                          output int lat, output logic [127:0] rdata);
        req_addr = a;
        wb_data  = d;
        if (is_wb) wb_req = 1'b1; else rd_req = 1'b1;
        lat   = -1;
        rdata = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (is_wb ? verified : l3_ready) begin
                lat   = k;
                rdata = l2_data;
                break;
            end
        end
        wb_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if ({l3_ready, verified, mm_rreq, mm_wreq, hit, miss} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 000000", {l3_ready, verified, mm_rreq, mm_wreq, hit, miss});
        end
        tests++;
        if (mm_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_addr: got %h expected 0", mm_addr);
        end
        tests++;
        if ((l2_data | mm_wdata) !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h expected 0", l2_data, mm_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_miss;
        int lat, m0, r0, w0;
        logic [127:0] rd;
        m0 = misses; r0 = mem_reads; w0 = mem_writes;
        mm_rdata = D1;
        do_req(1'b0, 32'h0000_0100, '0, lat, rd);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL miss_latency: got %0d expected 4", lat); end
        tests++;
        if (rd !== D1) begin fails++; $display("FAIL miss_data: got %h expected %h", rd, D1); end
        tests++;
        if (misses - m0 !== 1) begin fails++; $display("FAIL miss_pulse: got %0d expected 1", misses - m0); end
        tests++;
        if (last_rd_addr !== 32'h0000_0100 || mem_reads - r0 !== 1) begin
            fails++;
            $display("FAIL miss_fetch: got addr %h reads %0d expected 00000100 1", last_rd_addr, mem_reads - r0);
        end
        tests++;
        if (mem_writes !== w0) begin fails++; $display("FAIL miss_no_evict: got %0d expected %0d", mem_writes, w0); end
    endtask

    task automatic test_read_hit;
        int lat, h0, r0;
        logic [127:0] rd;
        h0 = hits; r0 = mem_reads;
        do_req(1'b0, 32'h4000_0100, '0, lat, rd);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL hit_latency: got %0d expected 2", lat); end
        tests++;
        if (rd !== D1) begin fails++; $display("FAIL hit_data: got %h expected %h", rd, D1); end
        tests++;
        if (hits - h0 !== 1 || mem_reads !== r0) begin
            fails++;
            $display("FAIL hit_traffic: got hits %0d reads %0d expected 1 0", hits - h0, mem_reads - r0);
        end
    endtask

    task automatic test_wb_evict;
        int lat, w0, r0;
        logic [127:0] rd;
        w0 = mem_writes; r0 = mem_reads;
        do_req(1'b1, 32'h0000_0100, D2, lat, rd);
        tests++;
        if (lat !== 2 || mem_writes !== w0) begin
            fails++;
            $display("FAIL wb_hit: got lat %0d writes %0d expected 2 0", lat, mem_writes - w0);
        end
        mm_rdata = D3;
        // Same index, new tag, with ID and byte-offset bits set that must not reach memory.
        do_req(1'b0, 32'hC000_050C, '0, lat, rd);
        tests++;
        if (lat !== 6) begin fails++; $display("FAIL evict_latency: got %0d expected 6", lat); end
        tests++;
        if (last_wr_addr !== 32'h0000_0100 || last_wr_data !== D2 || mem_writes - w0 !== 1) begin
            fails++;
            $display("FAIL evict_write: got %h %h expected 00000100 %h", last_wr_addr, last_wr_data, D2);
        end
        tests++;
        if (last_rd_addr !== 32'h0000_0500 || mem_reads - r0 !== 1) begin
            fails++;
            $display("FAIL evict_fetch: got %h expected 00000500", last_rd_addr);
        end
        tests++;
        if (rd !== D3) begin fails++; $display("FAIL evict_data: got %h expected %h", rd, D3); end
    endtask

    task automatic test_simultaneous;
        int vk, rk, vcnt, rcnt, h0;
        logic [127:0] rd;
        vk = -1; rk = -1; vcnt = 0; rcnt = 0; rd = '0; h0 = hits;
        req_addr = 32'h0000_0500;
        wb_data  = D4;
        wb_req   = 1'b1;
        rd_req   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (verified) begin
                vcnt++;
                if (vk < 0) vk = k;
                wb_req = 1'b0;
            end
            if (l3_ready) begin
                rcnt++;
                if (rk < 0) begin rk = k; rd = l2_data; end
                rd_req = 1'b0;
            end
        end
        wb_req = 1'b0;
        rd_req = 1'b0;
        tests++;
        if (vk !== 2 || vcnt !== 1) begin
            fails++;
            $display("FAIL both_wb_first: got at %0d width %0d expected at 2 width 1", vk, vcnt);
        end
        tests++;
        if (rk !== 5 || rcnt !== 1) begin
            fails++;
            $display("FAIL both_read_after: got at %0d width %0d expected at 5 width 1", rk, rcnt);
        end
        tests++;
        if (rd !== D4 || hits - h0 !== 2) begin
            fails++;
            $display("FAIL both_read_data: got %h hits %0d expected %h 2", rd, hits - h0, D4);
        end
    endtask

    task automatic test_wb_miss_clean;
        int lat, w0, r0, m0;
        logic [127:0] rd;
        w0 = mem_writes; r0 = mem_reads; m0 = misses;
        do_req(1'b1, 32'h0000_0200, D6, lat, rd);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL wbmiss_latency: got %0d expected 2", lat); end
        tests++;
        if (mem_writes !== w0 || mem_reads !== r0 || misses - m0 !== 1) begin
            fails++;
            $display("FAIL wbmiss_traffic: got w %0d r %0d miss %0d expected 0 0 1",
                     mem_writes - w0, mem_reads - r0, misses - m0);
        end
        mm_rdata = D7;
        do_req(1'b0, 32'h0000_0600, '0, lat, rd);
        tests++;
        if (lat !== 6 || last_wr_addr !== 32'h0000_0200 || last_wr_data !== D6) begin
            fails++;
            $display("FAIL wbmiss_evict: got lat %0d %h %h expected 6 00000200 %h", lat, last_wr_addr, last_wr_data, D6);
        end
        tests++;
        if (rd !== D7) begin fails++; $display("FAIL wbmiss_read: got %h expected %h", rd, D7); end
    endtask

    task automatic test_reset_mid_fetch;
        int lat, w0, m0;
        bit seen;
        logic [127:0] rd;
        seen = 1'b0;
        req_addr = 32'h0000_0300;
        rd_req   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mm_rreq) begin seen = 1'b1; break; end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL midfetch_req: got no read request expected one"); end
        reset = 1'b0;
        #1;
        tests++;
        if ({l3_ready, verified, mm_rreq, mm_wreq, hit, miss} !== 6'b0 || mm_addr !== 32'h0
            || (l2_data | mm_wdata) !== 128'h0) begin
            fails++;
            $display("FAIL midfetch_outputs: got ctrl %b addr %h expected 0", {l3_ready, verified, mm_rreq, mm_wreq, hit, miss}, mm_addr);
        end
        rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        w0 = mem_writes; m0 = misses;
        mm_rdata = D8;
        // 0x500 was valid and dirty; after reset it must miss and its dirty data is gone.
        do_req(1'b0, 32'h0000_0500, '0, lat, rd);
        tests++;
        if (lat !== 4 || misses - m0 !== 1 || mem_writes !== w0) begin
            fails++;
            $display("FAIL post_reset_miss: got lat %0d miss %0d writes %0d expected 4 1 0", lat, misses - m0, mem_writes - w0);
        end
        tests++;
        if (rd !== D8) begin fails++; $display("FAIL post_reset_data: got %h expected %h", rd, D8); end
    endtask

    initial begin
        mm_rdata = '0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_wb_evict();
        test_simultaneous();
        test_wb_miss_clean();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
